// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program sequencer: next-PC select codes
// and the stack-level width.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_INC  = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_CALL = 3'd3,
    SEL_RET  = 3'd4
  } sel_e;

  // Bits needed to count 0..depth stack entries inclusive.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO with level counter; push/pop are ignored when they
// would overflow or underflow.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [AW-1:0]             push_data,
  output logic [AW-1:0]             top,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = lvl_w(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [LW-1:0] level_q;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] rd_idx;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & ~full & ~pop_ok;
  assign wr_idx  = PW'(level_q);
  assign rd_idx  = PW'(level_q - LW'(1));
  assign level   = level_q;
  assign top     = empty ? '0 : mem[rd_idx];

  // Entry storage needs no reset; only slots below level_q are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_idx] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else if (pop_ok) begin
      level_q <= level_q - LW'(1);
    end else if (push_ok) begin
      level_q <= level_q + LW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with increment / relative jump / call / return selection
// over a built-in return stack, plus sticky overflow/underflow flags.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned   AW        = 12,
  parameter int unsigned   DEPTH     = 8,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    jump,
  input  logic                    call,
  input  logic                    ret,
  input  logic [AW-1:0]           offset,
  input  logic                    err_clr,
  output logic [AW-1:0]           pc,
  output logic [AW-1:0]           stk_top,
  output logic [lvl_w(DEPTH)-1:0] stk_level,
  output logic                    stk_full,
  output logic                    stk_empty,
  output logic                    err_ovf,
  output logic                    err_unf
);

  sel_e          sel_c;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_inc_c;
  logic [AW-1:0] pc_tgt_c;
  logic [AW-1:0] pc_nxt_c;
  logic          set_ovf_c;
  logic          set_unf_c;
  logic          ovf_q;
  logic          unf_q;

  assign pc_inc_c = pc_q + AW'(1);
  assign pc_tgt_c = pc_q + offset;

  // Priority decode: ret > call > jump > increment; failed ret/call fall back to increment.
  always_comb begin
    sel_c     = SEL_HOLD;
    set_ovf_c = 1'b0;
    set_unf_c = 1'b0;
    if (en) begin
      if (ret) begin
        sel_c     = stk_empty ? SEL_INC : SEL_RET;
        set_unf_c = stk_empty;
      end else if (call) begin
        sel_c     = stk_full ? SEL_INC : SEL_CALL;
        set_ovf_c = stk_full;
      end else if (jump) begin
        sel_c = SEL_JMP;
      end else begin
        sel_c = SEL_INC;
      end
    end
  end

  always_comb begin
    pc_nxt_c = pc_q;
    case (sel_c)
      SEL_INC:  pc_nxt_c = pc_inc_c;
      SEL_JMP:  pc_nxt_c = pc_tgt_c;
      SEL_CALL: pc_nxt_c = pc_tgt_c;
      SEL_RET:  pc_nxt_c = stk_top;
      default:  pc_nxt_c = pc_q;
    endcase
  end

  ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (sel_c == SEL_CALL),
    .pop       (sel_c == SEL_RET),
    .push_data (pc_inc_c),
    .top       (stk_top),
    .level     (stk_level),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // A new error event overrides a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q <= pc_nxt_c;
      if (set_ovf_c)    ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
      if (set_unf_c)    unf_q <= 1'b1;
      else if (err_clr) unf_q <= 1'b0;
    end
  end

  assign pc      = pc_q;
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_pc_sequencer;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = 4;
  localparam int          MODV  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, jump, call, ret, err_clr;
  logic [AW-1:0] offset;
  logic [AW-1:0] pc, stk_top;
  logic [LW-1:0] stk_level;
  logic          stk_full, stk_empty, err_ovf, err_unf;

  int nchecks = 0;
  int nerrors = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_ovf, m_unf;

  pc_sequencer #(.AW(AW), .DEPTH(DEPTH), .RESET_VEC('0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .jump(jump), .call(call), .ret(ret),
    .offset(offset), .err_clr(err_clr), .pc(pc), .stk_top(stk_top),
    .stk_level(stk_level), .stk_full(stk_full), .stk_empty(stk_empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, jump, call, ret, err_clr;
    logic [AW-1:0] offset;
    int exp_pc, exp_lvl, exp_top;
    bit exp_ovf, exp_unf;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endfunction

  function automatic void model_step(bit e, bit j, bit c, bit r, int off, bit clr);
    bit sov = 0, sun = 0;
    if (e) begin
      if (r) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_pc = (m_pc + 1) % MODV; sun = 1; end
      end else if (c) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back((m_pc + 1) % MODV);
          m_pc = (m_pc + off) % MODV;
        end else begin
          m_pc = (m_pc + 1) % MODV;
          sov = 1;
        end
      end else if (j) m_pc = (m_pc + off) % MODV;
      else m_pc = (m_pc + 1) % MODV;
    end
    m_ovf = sov ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = sun ? 1'b1 : (clr ? 1'b0 : m_unf);
  endfunction

  task automatic check_model(input string tag);
    int top;
    top = (m_stk.size() > 0) ? m_stk[$] : 0;
    chk({tag, ".pc"},    int'(pc),        m_pc);
    chk({tag, ".level"}, int'(stk_level), m_stk.size());
    chk({tag, ".top"},   int'(stk_top),   top);
    chk({tag, ".full"},  int'(stk_full),  int'(m_stk.size() == DEPTH));
    chk({tag, ".empty"}, int'(stk_empty), int'(m_stk.size() == 0));
    chk({tag, ".ovf"},   int'(err_ovf),   int'(m_ovf));
    chk({tag, ".unf"},   int'(err_unf),   int'(m_unf));
  endtask

  // Drive one cycle of inputs, clock it, update the model, sample after the edge.
  task automatic step(input bit e, input bit j, input bit c, input bit r,
                      input logic [AW-1:0] off, input bit clr);
    en = e; jump = j; call = c; ret = r; offset = off; err_clr = clr;
    @(posedge clk);
    model_step(e, j, c, r, int'(off), clr);
    #1;
  endtask

  task automatic do_reset();
    en = 0; jump = 0; call = 0; ret = 0; offset = '0; err_clr = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  function automatic vec_t mk(bit e, bit j, bit c, bit r, int off, bit clr,
                              int p, int l, int t, bit o, bit u);
    vec_t v;
    v.en = e; v.jump = j; v.call = c; v.ret = r; v.offset = AW'(off); v.err_clr = clr;
    v.exp_pc = p; v.exp_lvl = l; v.exp_top = t; v.exp_ovf = o; v.exp_unf = u;
    return v;
  endfunction

  initial begin
    //            en j c r  off   clr  pc     lvl top    ovf unf
    vecs[0]  = mk(1, 0,0,0, 0,     0,  'h001, 0, 0,     0, 0);
    vecs[1]  = mk(1, 0,0,0, 0,     0,  'h002, 0, 0,     0, 0);
    vecs[2]  = mk(1, 0,0,0, 0,     0,  'h003, 0, 0,     0, 0);
    vecs[3]  = mk(1, 1,0,0, 'h00D, 0,  'h010, 0, 0,     0, 0);
    vecs[4]  = mk(1, 0,1,0, 'h020, 0,  'h030, 1, 'h011, 0, 0);
    vecs[5]  = mk(1, 0,0,1, 0,     0,  'h011, 0, 0,     0, 0);
    vecs[6]  = mk(1, 1,0,0, 'hFF4, 0,  'h005, 0, 0,     0, 0);
    vecs[7]  = mk(1, 1,0,0, 'hFFE, 0,  'h003, 0, 0,     0, 0);
    vecs[8]  = mk(1, 1,0,0, 'hFFC, 0,  'hFFF, 0, 0,     0, 0);
    vecs[9]  = mk(1, 0,0,0, 0,     0,  'h000, 0, 0,     0, 0);
    vecs[10] = mk(1, 0,0,1, 0,     0,  'h001, 0, 0,     0, 1);
    vecs[11] = mk(0, 0,0,0, 0,     1,  'h001, 0, 0,     0, 0);
    vecs[12] = mk(1, 0,1,0, 'h010, 0,  'h011, 1, 'h002, 0, 0);
    vecs[13] = mk(1, 1,1,1, 'h100, 0,  'h002, 0, 0,     0, 0);
    vecs[14] = mk(1, 0,1,0, 'h005, 0,  'h007, 1, 'h003, 0, 0);
    vecs[15] = mk(0, 1,1,1, 'h100, 0,  'h007, 1, 'h003, 0, 0);
    vecs[16] = mk(1, 0,0,1, 0,     1,  'h003, 0, 0,     0, 0);
    vecs[17] = mk(1, 0,0,1, 0,     1,  'h004, 0, 0,     0, 1);
    vecs[18] = mk(1, 0,0,0, 0,     1,  'h005, 0, 0,     0, 0);

    rst_n = 1'b1;
    en = 0; jump = 0; call = 0; ret = 0; offset = '0; err_clr = 0;
    #2;
    do_reset();
    chk("reset.pc", int'(pc), 0);
    chk("reset.level", int'(stk_level), 0);
    chk("reset.empty", int'(stk_empty), 1);
    chk("reset.full", int'(stk_full), 0);
    chk("reset.top", int'(stk_top), 0);
    chk("reset.flags", int'({err_ovf, err_unf}), 0);

    // Directed table
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].jump, vecs[i].call, vecs[i].ret, vecs[i].offset, vecs[i].err_clr);
      chk($sformatf("vec%0d.pc", i),    int'(pc),        vecs[i].exp_pc);
      chk($sformatf("vec%0d.level", i), int'(stk_level), vecs[i].exp_lvl);
      chk($sformatf("vec%0d.top", i),   int'(stk_top),   vecs[i].exp_top);
      chk($sformatf("vec%0d.ovf", i),   int'(err_ovf),   int'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d.unf", i),   int'(err_unf),   int'(vecs[i].exp_unf));
    end

    // Asynchronous reset mid-stream: takes effect without a clock edge
    step(1, 0, 1, 0, 'h040, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst.pc", int'(pc), 0);
    chk("async_rst.level", int'(stk_level), 0);
    chk("async_rst.empty", int'(stk_empty), 1);
    model_reset();
    #2;
    rst_n = 1'b1;
    #1;

    // Fill the stack, overflow once, unwind in LIFO order, then underflow
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0, 1, 0, 'h100, 0);
      chk($sformatf("fill%0d.pc", i), int'(pc), 'h100 * i);
      chk($sformatf("fill%0d.top", i), int'(stk_top), 'h100 * (i - 1) + 1);
    end
    chk("fill.full", int'(stk_full), 1);
    step(1, 0, 1, 0, 'h100, 0);
    chk("ovf.pc", int'(pc), 'h801);
    chk("ovf.flag", int'(err_ovf), 1);
    chk("ovf.level", int'(stk_level), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 1, '0, 0);
      chk($sformatf("unwind%0d.pc", i), int'(pc), 'h701 - 'h100 * i);
    end
    chk("unwind.empty", int'(stk_empty), 1);
    step(1, 0, 0, 1, '0, 0);
    chk("unf.pc", int'(pc), 'h002);
    chk("unf.flag", int'(err_unf), 1);
    chk("unf.ovf_sticky", int'(err_ovf), 1);
    step(1, 0, 0, 0, '0, 1);
    chk("clr.flags", int'({err_ovf, err_unf}), 0);
    check_model("seq");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit e, j, c, r, clr;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        check_model("rnd_rst");
      end
      e   = ($urandom_range(0, 9) != 0);
      r   = ($urandom_range(0, 3) == 0);
      c   = ($urandom_range(0, 2) == 0);
      j   = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step(e, j, c, r, AW'($urandom), clr);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
